cip_issue_ctl: RTL and testbench

Assembles the current instruction parcel (CIP) and lower instruction parcel (LIP) from the instruction-buffer parcel stream, and holds the instruction until the issue-check logic accepts it. It feeds the S, A, V and branch schedulers directly: `o_cip`, `o_cip_vld` and `o_issue_vld` drive their `i_cip`, `i_cip_vld` and `i_issue_vld` inputs. It also maintains the parcel address counter (P) and applies branch redirects.

---
 rtl/cip_issue_ctl.sv | 142 ++++++++++++++
 tb/tb_cip_issue_ctl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cip_issue_ctl.sv
// cip_issue_ctl
//
// Builds the current instruction parcel (CIP) and, for two-parcel instructions,
// the lower instruction parcel (LIP) from the instruction-buffer parcel stream.
// It then holds the assembled instruction until the schedulers permit issue.
// The block also keeps the parcel address counter P and applies branch redirects.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   i_nip/_vld      next parcel from the instruction buffers and its valid
//   o_nip_rd        parcel popped this cycle
//   i_fu_issue      OR of scheduler issue-permits for the held instruction
//   i_branch/_addr  redirect: flush the held instruction and reload P
//   o_cip, o_lip    held upper / lower parcel (o_lip is 0 for one-parcel)
//   o_cip_vld       a complete instruction is held
//   o_two_parcel    the held instruction is two-parcel
//   o_issue_vld     the held instruction issues this cycle
//   o_p_addr        address of the next parcel to consume
module cip_issue_ctl #(
  parameter int unsigned PW = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   i_nip,
  input  logic          i_nip_vld,
  output logic          o_nip_rd,
  input  logic          i_fu_issue,
  input  logic          i_branch,
  input  logic [PW-1:0] i_branch_addr,
  output logic [15:0]   o_cip,
  output logic [15:0]   o_lip,
  output logic          o_cip_vld,
  output logic          o_two_parcel,
  output logic          o_issue_vld,
  output logic [PW-1:0] o_p_addr
);

  // StUpper: the upper parcel is held and the lower parcel is still awaited.
  typedef enum logic [1:0] {StEmpty, StUpper, StFull} state_e;

  state_e        state_q, state_d;
  logic [15:0]   cip_q, cip_d;
  logic [15:0]   lip_q, lip_d;
  logic          two_q, two_d;
  logic [PW-1:0] p_q, p_d;

  logic          issue;
  logic          nip_rd;
  logic          nip_two;

  // Two-parcel opcodes, gh = parcel[15:9] in octal:
  // 006-017, 020, 021, 040, 041, 100-137.
  function automatic logic is_two_parcel(input logic [15:0] parcel);
    logic [6:0] gh;
    gh = parcel[15:9];
    return ((gh >= 7'o006) && (gh <= 7'o021)) ||
           (gh == 7'o040) || (gh == 7'o041) ||
           ((gh >= 7'o100) && (gh <= 7'o137));
  endfunction

  assign nip_two = is_two_parcel(i_nip);

  // A branch or reset blocks both issue and pop in the same cycle.
  always_comb begin
    issue  = (state_q == StFull) & i_fu_issue & ~i_branch & ~rst;
    nip_rd = i_nip_vld & ~i_branch & ~rst & ((state_q != StFull) | issue);
  end

  always_comb begin
    state_d = state_q;
    cip_d   = cip_q;
    lip_d   = lip_q;
    two_d   = two_q;
    p_d     = p_q;

    if (i_branch) begin
      // cip_q is left as it is; it is not valid in StEmpty.
      state_d = StEmpty;
      lip_d   = '0;
      p_d     = i_branch_addr;
    end else begin
      if (nip_rd) begin
        p_d = p_q + PW'(1);
      end
      unique case (state_q)
        StEmpty: begin
          if (nip_rd) begin
            cip_d   = i_nip;
            lip_d   = '0;
            two_d   = nip_two;
            state_d = nip_two ? StUpper : StFull;
          end
        end
        StUpper: begin
          if (nip_rd) begin
            lip_d   = i_nip;
            state_d = StFull;
          end
        end
        StFull: begin
          if (issue) begin
            if (nip_rd) begin
              // Back-to-back issue: the next instruction loads as the current one leaves.
              cip_d   = i_nip;
              lip_d   = '0;
              two_d   = nip_two;
              state_d = nip_two ? StUpper : StFull;
            end else begin
              state_d = StEmpty;
            end
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      cip_q   <= '0;
      lip_q   <= '0;
      two_q   <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cip_q   <= cip_d;
      lip_q   <= lip_d;
      two_q   <= two_d;
      p_q     <= p_d;
    end
  end

  assign o_nip_rd     = nip_rd;
  assign o_issue_vld  = issue;
  assign o_cip_vld    = (state_q == StFull);
  assign o_cip        = cip_q;
  assign o_lip        = lip_q;
  assign o_two_parcel = two_q;
  assign o_p_addr     = p_q;

endmodule

// File: tb/tb_cip_issue_ctl.sv
module tb_cip_issue_ctl;

  localparam int unsigned PW = 22;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   i_nip;
  logic          i_nip_vld;
  logic          o_nip_rd;
  logic          i_fu_issue;
  logic          i_branch;
  logic [PW-1:0] i_branch_addr;
  logic [15:0]   o_cip;
  logic [15:0]   o_lip;
  logic          o_cip_vld;
  logic          o_two_parcel;
  logic          o_issue_vld;
  logic [PW-1:0] o_p_addr;

  int total = 0;
  int bad   = 0;

  cip_issue_ctl #(.PW(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_nip        (i_nip),
    .i_nip_vld    (i_nip_vld),
    .o_nip_rd     (o_nip_rd),
    .i_fu_issue   (i_fu_issue),
    .i_branch     (i_branch),
    .i_branch_addr(i_branch_addr),
    .o_cip        (o_cip),
    .o_lip        (o_lip),
    .o_cip_vld    (o_cip_vld),
    .o_two_parcel (o_two_parcel),
    .o_issue_vld  (o_issue_vld),
    .o_p_addr     (o_p_addr)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_nip_vld = 1'b0; i_fu_issue = 1'b0; i_branch = 1'b0;
    i_nip = '0; i_branch_addr = '0;
    step(); step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_nip_vld = 1'b1; i_nip = 16'h6000; i_fu_issue = 1'b1;
    i_branch = 1'b0; i_branch_addr = '0;
    step(); step();
    total++; if (o_nip_rd !== 1'b0) begin bad++; $display("FAIL rst_nip_rd got=%b exp=0", o_nip_rd); end
    total++; if (o_issue_vld !== 1'b0) begin bad++; $display("FAIL rst_issue got=%b exp=0", o_issue_vld); end
    total++; if (o_cip_vld !== 1'b0) begin bad++; $display("FAIL rst_cip_vld got=%b exp=0", o_cip_vld); end
    total++; if (o_cip !== 16'h0) begin bad++; $display("FAIL rst_cip got=%h exp=0", o_cip); end
    total++; if (o_lip !== 16'h0) begin bad++; $display("FAIL rst_lip got=%h exp=0", o_lip); end
    total++; if (o_two_parcel !== 1'b0) begin bad++; $display("FAIL rst_two got=%b exp=0", o_two_parcel); end
    total++; if (o_p_addr !== '0) begin bad++; $display("FAIL rst_p got=%h exp=0", o_p_addr); end
    rst = 1'b0;
    #1;
    total++; if (o_nip_rd !== 1'b1) begin bad++; $display("FAIL rst_first_rd got=%b exp=1", o_nip_rd); end
    i_nip_vld = 1'b0;
    #1;
    i_nip_vld = 1'b1;
    step();
    i_nip_vld = 1'b0; i_fu_issue = 1'b0;
    total++; if (o_cip !== 16'h6000) begin bad++; $display("FAIL rst_first_cip got=%h exp=6000", o_cip); end
    total++; if (o_cip_vld !== 1'b1) begin bad++; $display("FAIL rst_first_vld got=%b exp=1", o_cip_vld); end
    total++; if (o_p_addr !== 22'd1) begin bad++; $display("FAIL rst_first_p got=%h exp=1", o_p_addr); end
  endtask

  task automatic test_one_parcel_stream();
    do_reset();
    i_nip = 16'h6000; i_nip_vld = 1'b1; i_fu_issue = 1'b1;
    total++; if (o_issue_vld !== 1'b0) begin bad++; $display("FAIL stream_no_early_issue got=%b exp=0", o_issue_vld); end
    for (int i = 1; i <= 3; i++) begin
      step();
      if (i == 3) begin
        i_nip_vld = 1'b0;
        #1;
      end
      total++; if (o_issue_vld !== 1'b1) begin bad++; $display("FAIL stream_issue[%0d] got=%b exp=1", i, o_issue_vld); end
      total++; if (o_p_addr !== PW'(i)) begin bad++; $display("FAIL stream_p[%0d] got=%h exp=%h", i, o_p_addr, i); end
      total++; if (o_lip !== 16'h0) begin bad++; $display("FAIL stream_lip[%0d] got=%h exp=0", i, o_lip); end
      total++; if (o_nip_rd !== (i != 3)) begin bad++; $display("FAIL stream_rd[%0d] got=%b exp=%b", i, o_nip_rd, i != 3); end
    end
    step();
    total++; if (o_cip_vld !== 1'b0) begin bad++; $display("FAIL stream_drain_vld got=%b exp=0", o_cip_vld); end
    total++; if (o_p_addr !== 22'd3) begin bad++; $display("FAIL stream_drain_p got=%h exp=3", o_p_addr); end
    i_fu_issue = 1'b0;
  endtask

  task automatic test_two_parcel();
    do_reset();
    i_nip = 16'h2000; i_nip_vld = 1'b1; i_fu_issue = 1'b1;
    step();
    i_nip = 16'h1234;
    #1;
    total++; if (o_cip_vld !== 1'b0) begin bad++; $display("FAIL two_upper_vld got=%b exp=0", o_cip_vld); end
    total++; if (o_issue_vld !== 1'b0) begin bad++; $display("FAIL two_upper_issue got=%b exp=0", o_issue_vld); end
    total++; if (o_nip_rd !== 1'b1) begin bad++; $display("FAIL two_upper_rd got=%b exp=1", o_nip_rd); end
    step();
    i_nip_vld = 1'b0;
    #1;
    total++; if (o_cip !== 16'h2000) begin bad++; $display("FAIL two_cip got=%h exp=2000", o_cip); end
    total++; if (o_lip !== 16'h1234) begin bad++; $display("FAIL two_lip got=%h exp=1234", o_lip); end
    total++; if (o_two_parcel !== 1'b1) begin bad++; $display("FAIL two_flag got=%b exp=1", o_two_parcel); end
    total++; if (o_cip_vld !== 1'b1) begin bad++; $display("FAIL two_vld got=%b exp=1", o_cip_vld); end
    total++; if (o_issue_vld !== 1'b1) begin bad++; $display("FAIL two_issue got=%b exp=1", o_issue_vld); end
    total++; if (o_p_addr !== 22'd2) begin bad++; $display("FAIL two_p got=%h exp=2", o_p_addr); end
    step();
    total++; if (o_cip_vld !== 1'b0) begin bad++; $display("FAIL two_after_vld got=%b exp=0", o_cip_vld); end
    i_fu_issue = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    i_nip = 16'h6000; i_nip_vld = 1'b1; i_fu_issue = 1'b0;
    step();
    i_nip = 16'h6001;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++; if (o_nip_rd !== 1'b0) begin bad++; $display("FAIL stall_rd[%0d] got=%b exp=0", i, o_nip_rd); end
      total++; if (o_issue_vld !== 1'b0) begin bad++; $display("FAIL stall_issue[%0d] got=%b exp=0", i, o_issue_vld); end
      total++; if (o_cip !== 16'h6000) begin bad++; $display("FAIL stall_cip[%0d] got=%h exp=6000", i, o_cip); end
      total++; if (o_p_addr !== 22'd1) begin bad++; $display("FAIL stall_p[%0d] got=%h exp=1", i, o_p_addr); end
      step();
    end
    i_fu_issue = 1'b1;
    #1;
    total++; if (o_issue_vld !== 1'b1) begin bad++; $display("FAIL stall_release_issue got=%b exp=1", o_issue_vld); end
    total++; if (o_nip_rd !== 1'b1) begin bad++; $display("FAIL stall_release_rd got=%b exp=1", o_nip_rd); end
    step();
    i_nip_vld = 1'b0; i_fu_issue = 1'b0;
    #1;
    total++; if (o_cip !== 16'h6001) begin bad++; $display("FAIL stall_next_cip got=%h exp=6001", o_cip); end
    total++; if (o_p_addr !== 22'd2) begin bad++; $display("FAIL stall_next_p got=%h exp=2", o_p_addr); end
  endtask

  task automatic test_branch_upper();
    do_reset();
    i_nip = 16'h2000; i_nip_vld = 1'b1; i_fu_issue = 1'b1;
    step();
    i_branch = 1'b1; i_branch_addr = 22'h000100;
    #1;
    total++; if (o_nip_rd !== 1'b0) begin bad++; $display("FAIL br_up_rd got=%b exp=0", o_nip_rd); end
    step();
    i_branch = 1'b0; i_nip = 16'h6000;
    #1;
    total++; if (o_p_addr !== 22'h000100) begin bad++; $display("FAIL br_up_p got=%h exp=000100", o_p_addr); end
    total++; if (o_cip_vld !== 1'b0) begin bad++; $display("FAIL br_up_vld got=%b exp=0", o_cip_vld); end
    total++; if (o_issue_vld !== 1'b0) begin bad++; $display("FAIL br_up_issue got=%b exp=0", o_issue_vld); end
    step();
    i_nip_vld = 1'b0; i_fu_issue = 1'b0;
    #1;
    total++; if (o_cip !== 16'h6000) begin bad++; $display("FAIL br_up_cip got=%h exp=6000", o_cip); end
    total++; if (o_two_parcel !== 1'b0) begin bad++; $display("FAIL br_up_two got=%b exp=0", o_two_parcel); end
    total++; if (o_lip !== 16'h0) begin bad++; $display("FAIL br_up_lip got=%h exp=0", o_lip); end
    total++; if (o_cip_vld !== 1'b1) begin bad++; $display("FAIL br_up_full got=%b exp=1", o_cip_vld); end
    total++; if (o_p_addr !== 22'h000101) begin bad++; $display("FAIL br_up_p2 got=%h exp=000101", o_p_addr); end
  endtask

  task automatic test_branch_wrap();
    do_reset();
    i_nip = 16'h6000; i_nip_vld = 1'b1; i_fu_issue = 1'b0;
    step();
    // Branch in FULL with issue permitted: the branch wins.
    i_fu_issue = 1'b1; i_branch = 1'b1; i_branch_addr = 22'h3FFFFF;
    #1;
    total++; if (o_issue_vld !== 1'b0) begin bad++; $display("FAIL br_wins_issue got=%b exp=0", o_issue_vld); end
    total++; if (o_nip_rd !== 1'b0) begin bad++; $display("FAIL br_wins_rd got=%b exp=0", o_nip_rd); end
    step();
    i_branch = 1'b0; i_fu_issue = 1'b0;
    #1;
    total++; if (o_p_addr !== 22'h3FFFFF) begin bad++; $display("FAIL wrap_p_pre got=%h exp=3fffff", o_p_addr); end
    total++; if (o_cip_vld !== 1'b0) begin bad++; $display("FAIL wrap_vld_pre got=%b exp=0", o_cip_vld); end
    step();
    i_nip_vld = 1'b0;
    #1;
    total++; if (o_p_addr !== 22'h000000) begin bad++; $display("FAIL wrap_p got=%h exp=000000", o_p_addr); end
    total++; if (o_cip_vld !== 1'b1) begin bad++; $display("FAIL wrap_vld got=%b exp=1", o_cip_vld); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    i_nip = 16'h2000; i_nip_vld = 1'b1;
    step();
    rst = 1'b1;
    #1;
    total++; if (o_nip_rd !== 1'b0) begin bad++; $display("FAIL rstmid_rd got=%b exp=0", o_nip_rd); end
    step();
    rst = 1'b0; i_nip_vld = 1'b0;
    #1;
    total++; if (o_cip_vld !== 1'b0) begin bad++; $display("FAIL rstmid_vld got=%b exp=0", o_cip_vld); end
    total++; if (o_cip !== 16'h0) begin bad++; $display("FAIL rstmid_cip got=%h exp=0", o_cip); end
    total++; if (o_p_addr !== '0) begin bad++; $display("FAIL rstmid_p got=%h exp=0", o_p_addr); end
    i_nip = 16'h6000; i_nip_vld = 1'b1;
    step();
    i_nip_vld = 1'b0;
    #1;
    total++; if (o_cip_vld !== 1'b1) begin bad++; $display("FAIL rstmid_reload got=%b exp=1", o_cip_vld); end
  endtask

  // Opcode decode at the range edges; loaded from EMPTY, then flushed by a branch.
  task automatic test_decode();
    logic [15:0] parcels [10];
    logic        exp_two [10];
    parcels = '{16'h0A00, 16'h0C01, 16'h1E00, 16'h2400, 16'h4200,
                16'h4400, 16'h7E00, 16'h8000, 16'hBE00, 16'hC000};
    exp_two = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    i_fu_issue = 1'b0;
    for (int i = 0; i < 10; i++) begin
      i_nip = parcels[i]; i_nip_vld = 1'b1;
      step();
      i_nip_vld = 1'b0;
      #1;
      total++; if (o_two_parcel !== exp_two[i]) begin bad++; $display("FAIL dec_two[%h] got=%b exp=%b", parcels[i], o_two_parcel, exp_two[i]); end
      total++; if (o_cip_vld !== !exp_two[i]) begin bad++; $display("FAIL dec_vld[%h] got=%b exp=%b", parcels[i], o_cip_vld, !exp_two[i]); end
      i_branch = 1'b1; i_branch_addr = '0;
      step();
      i_branch = 1'b0;
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_one_parcel_stream();
    test_two_parcel();
    test_stall();
    test_branch_upper();
    test_branch_wrap();
    test_rst_mid();
    test_decode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
